// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-clock FIFO, write-clock domain only.
// Optional transfer statistics counter enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          w_full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   xfer_cnt
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   last_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              transfer;
  logic              burst_done;
  logic              release_own;
  logic [NUM_REQ-1:0] others;

  // First set bit of mask strictly after 'from', wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [ID_W-1:0]    from);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = from;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(from) + k) % NUM_REQ;
      if (!found && mask[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    transfer  = (state == S_GRANT) && req_valid[grant_id] && !w_full && !w_rst;
    req_ready = '0;
    if ((state == S_GRANT) && !w_full && !w_rst) begin
      req_ready[grant_id] = 1'b1;
    end
    w_inc  = transfer;
    w_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    busy   = (state == S_GRANT);
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    last_nxt    = last;
    cnt_nxt     = burst_cnt;
    burst_done  = transfer && (burst_cnt == CNT_W'(MAX_BURST - 1));
    release_own = burst_done ||
                  ((state == S_GRANT) && !transfer && !req_valid[grant_id]);
    others           = req_valid;
    others[grant_id] = 1'b0;

    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          grant_nxt = rr_pick(req_valid, last);
          last_nxt  = grant_nxt;
          cnt_nxt   = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (release_own) begin
          cnt_nxt = '0;
          // A burst-limit release with no competitor keeps the owner without an idle bubble.
          if (|others) begin
            grant_nxt = rr_pick(others, last);
            last_nxt  = grant_nxt;
          end else if (!burst_done) begin
            state_nxt = S_IDLE;
          end
        end else if (transfer) begin
          cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      last      <= ID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      xfer_cnt <= '0;
    end else if (w_inc && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            w_clk = 1'b0;
  logic            w_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            w_full = 1'b0;
  logic            w_inc;
  logic [DW-1:0]   w_data;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]     xfer_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .w_full   (w_full),
    .w_inc    (w_inc),
    .w_data   (w_data),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how many words it has written, who was served last.
  bit m_busy;
  int m_owner;
  int m_words;
  int m_last;
  int m_xcnt;

  // Stimulus state applied at the next step.
  logic [N-1:0]  v;
  logic [DW-1:0] d [N];
  bit            full;
  bit            rst;
  int            last_acc;

  logic [DW-1:0] cap_d[$];
  int            cap_id[$];

  function automatic int next_after(input int from, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(from + k) % N]) return (from + k) % N;
    end
    return from;
  endfunction

  task automatic step();
    bit           xfer;
    logic [N-1:0] exp_ready;
    logic [N-1:0] rivals;
    @(negedge w_clk);
    w_rst     = rst;
    w_full    = full;
    req_valid = v;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
    #1;
    xfer      = !rst && m_busy && v[m_owner] && !full;
    exp_ready = (!rst && m_busy && !full) ? (N'(1) << m_owner) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("w_inc",     64'(w_inc),     64'(xfer));
    check("w_data",    64'(w_data),    64'(d[m_owner]));
    check("grant_id",  64'(grant_id),  64'(m_owner));
    check("busy",      64'(busy),      64'(m_busy));
`ifdef FIFO_ARB_STATS_EN
    check("xfer_cnt",  64'(xfer_cnt),  64'(m_xcnt));
`endif
    if (w_inc) begin
      cap_d.push_back(w_data);
      cap_id.push_back(int'(grant_id));
    end
    last_acc = xfer ? m_owner : -1;

    if (rst) begin
      m_busy = 0; m_owner = 0; m_words = 0; m_last = N - 1; m_xcnt = 0;
    end else begin
      if (xfer && m_xcnt < 65535) m_xcnt++;
      if (!m_busy) begin
        if (v != '0) begin
          m_owner = next_after(m_last, v);
          m_last  = m_owner;
          m_words = 0;
          m_busy  = 1;
        end
      end else begin
        if (xfer) m_words++;
        if ((xfer && m_words == MB) || (!xfer && !v[m_owner])) begin
          rivals = v;
          rivals[m_owner] = 1'b0;
          if (rivals != '0) begin
            m_owner = next_after(m_last, rivals);
            m_last  = m_owner;
          end else if (!(xfer && m_words == MB)) begin
            m_busy = 0;
          end
          m_words = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; v = '0; full = 0;
    step();
    step();
    rst = 0;
    cap_d.delete();
    cap_id.delete();
  endtask

  task automatic produce_random();
    for (int i = 0; i < N; i++) begin
      if (last_acc == i) begin
        if ($urandom_range(9) < 7) begin
          v[i] = 1'b1;
          d[i] = DW'($urandom);
        end else begin
          v[i] = 1'b0;
        end
      end else if (!v[i]) begin
        if ($urandom_range(1) == 1) begin
          v[i] = 1'b1;
          d[i] = DW'($urandom);
        end
      end else if ($urandom_range(19) == 0) begin
        v[i] = 1'b0;
      end
    end
    full = ($urandom_range(4) == 0);
    rst  = ($urandom_range(199) == 0);
  endtask

  initial begin
    int idx;
    int guard;
    int n_cap;
    for (int i = 0; i < N; i++) d[i] = '0;
    v = '0; full = 0; rst = 1; last_acc = -1;
    m_busy = 0; m_owner = 0; m_words = 0; m_last = N - 1; m_xcnt = 0;

    // Single requester streaming A0..A5: burst of four, immediate re-grant, two more.
    do_reset();
    idx = 0; v = 4'b0001; d[0] = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_acc == 0) begin
        idx++;
        if (idx < 6) d[0] = 8'hA0 + DW'(idx);
        else v[0] = 1'b0;
      end
    end
    check("t1_count", 64'(cap_d.size()), 64'd6);
    for (int k = 0; k < 6 && k < cap_d.size(); k++) begin
      check("t1_data", 64'(cap_d[k]), 64'(8'hA0 + k));
    end

    // All requesters valid: bursts of MB words in order 0,1,2,3,0.
    do_reset();
    v = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = DW'(8'h10 * i);
    for (int c = 0; c < 22; c++) begin
      step();
      if (last_acc >= 0) d[last_acc] = DW'($urandom);
    end
    check("t2_count", 64'(cap_id.size() >= 20), 64'd1);
    for (int k = 0; k < 20 && k < cap_id.size(); k++) begin
      check("t2_order", 64'(cap_id[k]), 64'((k / MB) % N));
    end

    // Owner 2 stalled by w_full mid-burst, then resumes.
    do_reset();
    v = 4'b0100; d[2] = 8'h21;
    guard = 0;
    while (cap_d.size() < 2 && guard < 10) begin
      step();
      if (last_acc == 2) d[2] = d[2] + 8'd1;
      guard++;
    end
    check("t3_pre", 64'(cap_d.size()), 64'd2);
    full = 1;
    n_cap = cap_d.size();
    for (int c = 0; c < 5; c++) step();
    check("t3_stall", 64'(cap_d.size()), 64'(n_cap));
    full = 0;
    guard = 0;
    while (cap_d.size() < 4 && guard < 10) begin
      step();
      if (last_acc == 2) d[2] = d[2] + 8'd1;
      guard++;
    end
    check("t3_resume", 64'(cap_d.size()), 64'd4);
    for (int k = 0; k < cap_id.size(); k++) check("t3_owner", 64'(cap_id[k]), 64'd2);

    // Owner 1 drops valid after one word while requester 3 waits.
    do_reset();
    v = 4'b0010; d[1] = 8'h55; d[3] = 8'h77;
    guard = 0;
    while (last_acc != 1 && guard < 10) begin
      step();
      guard++;
    end
    check("t4_first", 64'(last_acc), 64'd1);
    v = 4'b1000;
    step();
    step();
    check("t4_switch", 64'(grant_id), 64'd3);
    check("t4_inc", 64'(w_inc), 64'd1);

    // Reset in the middle of an owner-3 burst; requester 0 then wins.
    do_reset();
    v = 4'b1000; d[3] = 8'h33; d[0] = 8'h0F;
    for (int c = 0; c < 3; c++) step();
    v = 4'b1001; rst = 1;
    step();
    check("t5_rst_inc", 64'(w_inc), 64'd0);
    rst = 0;
    step();
    check("t5_idle", 64'(busy), 64'd0);
    step();
    check("t5_winner", 64'(grant_id), 64'd0);

    // Randomized traffic with backpressure, valid drops and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      produce_random();
      step();
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturation of the transfer counter.
    do_reset();
    v = 4'b0001; full = 0;
    for (int c = 0; c < 70010; c++) begin
      step();
      if (last_acc == 0) d[0] = DW'($urandom);
    end
    check("stats_sat", 64'(xfer_cnt), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
